// File: rtl/execute_sequencer.sv
// execute_sequencer
// Sequences the execute stage between decode and memory. One instruction is
// accepted at a time. The executor is enabled for one cycle (ALU/branch) or for
// MUL_LATENCY/DIV_LATENCY cycles (MUL/DIV). The result is captured into a
// one-entry buffer and presented to the memory stage. A taken jump raises a
// one-cycle redirect/flush to the front end.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   dec_valid/dec_ready   decode handshake; dec_op_class, dec_rd describe the op
//   ex_enable             executor enable
//   ex_done/ex_result     executor result valid / data
//   ex_jump/ex_target     taken jump and its target (sampled on capture only)
//   mem_valid/mem_ready   output buffer handshake; mem_result, mem_rd payload
//   redirect_valid/_pc    one-cycle fetch redirect; flush_front mirrors it
//   busy                  sequencer not idle
module execute_sequencer #(
    parameter int XLEN        = 64,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 33
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [1:0]      dec_op_class,
    input  logic [4:0]      dec_rd,
    output logic            ex_enable,
    input  logic            ex_done,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_target,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_result,
    output logic [4:0]      mem_rd,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_front,
    output logic            busy
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MULTI, HOLD} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [4:0]    tag;
    logic          accept;
    logic          capture;

    // No accept while a redirect is live: decode output in that cycle is wrong-path.
    assign dec_ready = ((state == IDLE) | ((state == HOLD) & mem_ready))
                       & ~redirect_valid & ~reset;
    assign accept    = dec_valid & dec_ready;

    assign mem_valid   = (state == HOLD);
    assign busy        = (state != IDLE);
    assign flush_front = redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        ex_enable  = 1'b0;
        case (state)
            IDLE: ;
            EXEC: begin
                ex_enable = 1'b1;
                if (ex_done) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            MULTI: begin
                ex_enable = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else if (ex_done) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (mem_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Accept overrides the HOLD->IDLE drain so back-to-back ops skip IDLE.
        if (accept) begin
            if (!dec_op_class[1]) begin
                state_next = EXEC;
            end else begin
                state_next = MULTI;
                cnt_next   = dec_op_class[0] ? CW'(DIV_LATENCY - 1) : CW'(MUL_LATENCY - 1);
            end
        end
    end

    // Tag is separate from mem_rd: a back-to-back accept overwrites the tag
    // while the buffer still presents the previous instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag            <= '0;
            mem_result     <= '0;
            mem_rd         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            if (accept) tag <= dec_rd;
            if (capture) begin
                mem_result <= ex_result;
                mem_rd     <= tag;
            end
            redirect_valid <= capture & ex_jump;
            if (capture & ex_jump) redirect_pc <= ex_target;
        end
    end

endmodule

// File: tb/tb_execute_sequencer.sv
module tb_execute_sequencer;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            dec_valid;
    logic            dec_ready;
    logic [1:0]      dec_op_class;
    logic [4:0]      dec_rd;
    logic            ex_enable;
    logic            ex_done;
    logic [XLEN-1:0] ex_result;
    logic            ex_jump;
    logic [XLEN-1:0] ex_target;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_result;
    logic [4:0]      mem_rd;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_front;
    logic            busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute_sequencer #(.XLEN(XLEN), .MUL_LATENCY(3), .DIV_LATENCY(33)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_op_class(dec_op_class), .dec_rd(dec_rd),
        .ex_enable(ex_enable), .ex_done(ex_done), .ex_result(ex_result),
        .ex_jump(ex_jump), .ex_target(ex_target),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_result(mem_result), .mem_rd(mem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_front(flush_front), .busy(busy)
    );

    // Inputs change just after the falling edge; outputs are checked 1ns later,
    // well clear of the next rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        dec_valid = 0; dec_op_class = 0; dec_rd = 0;
        ex_done = 1; ex_result = 0; ex_jump = 0; ex_target = 0; mem_ready = 1;
    endtask

    task automatic test_reset();
        reset = 1; quiet_inputs();
        next_cycle(); next_cycle(); #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL rst_dec_ready got %b want 0", dec_ready); end
        checks++; if (ex_enable !== 1'b0) begin errors++; $display("FAIL rst_ex_enable got %b want 0", ex_enable); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b want 0", mem_valid); end
        checks++; if (mem_result !== 64'h0) begin errors++; $display("FAIL rst_mem_result got %h want 0", mem_result); end
        checks++; if (mem_rd !== 5'd0) begin errors++; $display("FAIL rst_mem_rd got %0d want 0", mem_rd); end
        checks++; if (redirect_valid !== 1'b0 || flush_front !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b/%b want 0/0", redirect_valid, flush_front); end
        checks++; if (redirect_pc !== 64'h0) begin errors++; $display("FAIL rst_redirect_pc got %h want 0", redirect_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        next_cycle(); reset = 0; #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready got %b want 1", dec_ready); end
    endtask

    task automatic test_alu();
        next_cycle();
        dec_valid = 1; dec_op_class = 2'b00; dec_rd = 5'd5;
        ex_done = 1; ex_result = 64'h1234; mem_ready = 1; #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL alu_accept got %b want 1", dec_ready); end
        next_cycle(); dec_valid = 0; #1;   // T+1
        checks++; if (ex_enable !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL alu_t1 en/mv got %b/%b want 1/0", ex_enable, mem_valid); end
        checks++; if (dec_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL alu_t1 rdy/busy got %b/%b want 0/1", dec_ready, busy); end
        next_cycle(); ex_result = 64'hFFFF; #1;   // T+2
        checks++; if (ex_enable !== 1'b0 || mem_valid !== 1'b1) begin errors++; $display("FAIL alu_t2 en/mv got %b/%b want 0/1", ex_enable, mem_valid); end
        checks++; if (mem_result !== 64'h1234 || mem_rd !== 5'd5) begin errors++; $display("FAIL alu_t2 data got %h/%0d want 1234/5", mem_result, mem_rd); end
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL alu_t2 dec_ready got %b want 1", dec_ready); end
        next_cycle(); #1;   // T+3
        checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL alu_t3 mv/busy got %b/%b want 0/0", mem_valid, busy); end
    endtask

    task automatic test_mul();
        next_cycle();
        dec_valid = 1; dec_op_class = 2'b10; dec_rd = 5'd7;
        ex_done = 1; ex_result = 64'hABCD; mem_ready = 0; #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL mul_accept got %b want 1", dec_ready); end
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            dec_valid = 0;
            mem_ready = (k == 6);
            ex_result = (k >= 4) ? 64'hDEAD : 64'hABCD;
            #1;
            checks++; if (ex_enable !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL mul_en k=%0d got %b want %b", k, ex_enable, (k >= 1 && k <= 3)); end
            checks++; if (mem_valid !== (k >= 4 && k <= 6)) begin errors++; $display("FAIL mul_mv k=%0d got %b want %b", k, mem_valid, (k >= 4 && k <= 6)); end
            checks++; if (dec_ready !== (k == 6 || k == 7)) begin errors++; $display("FAIL mul_rdy k=%0d got %b want %b", k, dec_ready, (k == 6 || k == 7)); end
            if (k >= 4 && k <= 6) begin
                checks++; if (mem_result !== 64'hABCD || mem_rd !== 5'd7) begin errors++; $display("FAIL mul_data k=%0d got %h/%0d want abcd/7", k, mem_result, mem_rd); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_end_busy got %b want 0", busy); end
    endtask

    task automatic test_branch();
        next_cycle();
        dec_valid = 1; dec_op_class = 2'b01; dec_rd = 5'd1;
        ex_done = 1; ex_result = 64'h104; ex_jump = 1; ex_target = 64'h8000_0040; mem_ready = 1; #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL br_accept got %b want 1", dec_ready); end
        next_cycle(); dec_valid = 0; #1;   // T+1
        checks++; if (ex_enable !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL br_t1 en/rv got %b/%b want 1/0", ex_enable, redirect_valid); end
        next_cycle(); dec_valid = 1; dec_op_class = 2'b00; dec_rd = 5'd30; ex_jump = 0; ex_target = 64'h0; #1;   // T+2
        checks++; if (redirect_valid !== 1'b1 || flush_front !== 1'b1) begin errors++; $display("FAIL br_t2 rv/flush got %b/%b want 1/1", redirect_valid, flush_front); end
        checks++; if (redirect_pc !== 64'h8000_0040) begin errors++; $display("FAIL br_t2 pc got %h want 80000040", redirect_pc); end
        checks++; if (mem_valid !== 1'b1 || mem_result !== 64'h104 || mem_rd !== 5'd1) begin errors++; $display("FAIL br_t2 buf got %b/%h/%0d want 1/104/1", mem_valid, mem_result, mem_rd); end
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL br_t2 dec_ready got %b want 0", dec_ready); end
        next_cycle(); dec_valid = 0; #1;   // T+3
        checks++; if (redirect_valid !== 1'b0 || flush_front !== 1'b0) begin errors++; $display("FAIL br_t3 rv/flush got %b/%b want 0/0", redirect_valid, flush_front); end
        checks++; if (mem_valid !== 1'b0 || busy !== 1'b0 || dec_ready !== 1'b1) begin errors++; $display("FAIL br_t3 mv/busy/rdy got %b/%b/%b want 0/0/1", mem_valid, busy, dec_ready); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        dec_valid = 1; dec_op_class = 2'b00; dec_rd = 5'd2; ex_done = 1; ex_result = 64'h11; mem_ready = 1;
        next_cycle(); dec_valid = 0;   // T+1
        next_cycle(); dec_valid = 1; dec_op_class = 2'b11; dec_rd = 5'd9; #1;   // T+2 (HOLD)
        checks++; if (mem_valid !== 1'b1 || mem_result !== 64'h11 || mem_rd !== 5'd2) begin errors++; $display("FAIL b2b_hold got %b/%h/%0d want 1/11/2", mem_valid, mem_result, mem_rd); end
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL b2b_same_edge_ready got %b want 1", dec_ready); end
        for (int k = 3; k <= 35; k++) begin
            next_cycle(); dec_valid = 0; ex_result = 64'h99; #1;
            checks++; if (ex_enable !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_div k=%0d en/mv got %b/%b want 1/0", k, ex_enable, mem_valid); end
        end
        next_cycle(); ex_result = 64'h77; #1;   // T+36
        checks++; if (mem_valid !== 1'b1 || mem_result !== 64'h99 || mem_rd !== 5'd9) begin errors++; $display("FAIL b2b_div_out got %b/%h/%0d want 1/99/9", mem_valid, mem_result, mem_rd); end
        checks++; if (ex_enable !== 1'b0) begin errors++; $display("FAIL b2b_div_en_off got %b want 0", ex_enable); end
        next_cycle(); #1;   // T+37
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", busy); end
    endtask

    task automatic test_stall();
        next_cycle();
        dec_valid = 1; dec_op_class = 2'b00; dec_rd = 5'd3;
        ex_done = 0; ex_jump = 1; ex_target = 64'hBAD; ex_result = 64'h0; mem_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); dec_valid = 0; #1;
            checks++; if (ex_enable !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL stall k=%0d en/mv got %b/%b want 1/0", k, ex_enable, mem_valid); end
        end
        next_cycle(); ex_done = 1; ex_jump = 0; ex_result = 64'h55; #1;   // T+5
        checks++; if (ex_enable !== 1'b1) begin errors++; $display("FAIL stall_t5_en got %b want 1", ex_enable); end
        next_cycle(); ex_result = 64'h66; #1;   // T+6
        checks++; if (mem_valid !== 1'b1 || mem_result !== 64'h55 || mem_rd !== 5'd3) begin errors++; $display("FAIL stall_out got %b/%h/%0d want 1/55/3", mem_valid, mem_result, mem_rd); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL stall_no_redirect got %b want 0", redirect_valid); end
        next_cycle(); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_multi();
        next_cycle();
        dec_valid = 1; dec_op_class = 2'b11; dec_rd = 5'd12; ex_done = 1; ex_jump = 1; ex_target = 64'h4444; mem_ready = 1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle(); dec_valid = 0;
        end
        next_cycle(); reset = 1; #1;   // T+13: MULTI with cnt=20
        checks++; if (busy !== 1'b1 || ex_enable !== 1'b1) begin errors++; $display("FAIL rstm_pre busy/en got %b/%b want 1/1", busy, ex_enable); end
        next_cycle(); reset = 0; #1;   // T+14
        checks++; if (busy !== 1'b0 || mem_valid !== 1'b0 || ex_enable !== 1'b0) begin errors++; $display("FAIL rstm_post busy/mv/en got %b/%b/%b want 0/0/0", busy, mem_valid, ex_enable); end
        checks++; if (redirect_valid !== 1'b0 || flush_front !== 1'b0) begin errors++; $display("FAIL rstm_redirect got %b/%b want 0/0", redirect_valid, flush_front); end
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready got %b want 1", dec_ready); end
        next_cycle(); #1;
        checks++; if (mem_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL rstm_later mv/rv got %b/%b want 0/0", mem_valid, redirect_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_branch();
        test_back_to_back();
        test_stall();
        test_reset_multi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
